// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - IF stage: PC register, next-PC select and IF/ID pipeline register
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] PCResult,
    output logic [31:0] PCAddResult,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCAddResult,
    output logic        IFID_Valid
);

    localparam logic [1:0] ST_BOOT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [31:0] PC_STEP = 32'(PC_INC);

    logic [1:0]  state;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        hold;

    assign PCAddResult = PCResult + PC_STEP;

    // Jump outranks a simultaneous taken branch; a redirect also beats Stall
    // since the stalled instruction is on the wrong path.
    always_comb begin
        redirect    = Jump | BranchTaken;
        redirect_pc = Jump ? JumpTarget : BranchTarget;
        hold        = Stall && (state != ST_BOOT);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            PCResult         <= RESET_PC;
            IFID_Instruction <= 32'h0;
            IFID_PCAddResult <= 32'h0;
            IFID_Valid       <= 1'b0;
            state            <= ST_BOOT;
        end else if (redirect) begin
            PCResult         <= redirect_pc;
            IFID_Instruction <= 32'h0;
            IFID_PCAddResult <= 32'h0;
            IFID_Valid       <= 1'b0;
            state            <= ST_REDIRECT;
        end else if (!hold) begin
            PCResult         <= PCAddResult;
            IFID_Instruction <= Instruction;
            IFID_PCAddResult <= PCAddResult;
            IFID_Valid       <= 1'b1;
            state            <= ST_RUN;
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - scoreboard-driven directed bench for pc_fetch_stage
module tb_pc_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] Instruction;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCAddResult;
    logic        IFID_Valid;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ifi;
        logic [31:0] ifpc;
        logic        v;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_pc;
    logic [31:0] m_ifi;
    logic [31:0] m_ifpc;
    logic        m_v;
    logic        m_boot;

    pc_fetch_stage dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .Jump             (Jump),
        .JumpTarget       (JumpTarget),
        .Instruction      (Instruction),
        .PCResult         (PCResult),
        .PCAddResult      (PCAddResult),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCAddResult (IFID_PCAddResult),
        .IFID_Valid       (IFID_Valid)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign Instruction = mem(PCResult);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, push the predicted post-edge state, then pop and compare.
    task automatic step(input logic rst_n, input logic st, input logic br,
                        input logic [31:0] bt, input logic jp, input logic [31:0] jt);
        exp_t e;
        exp_t got;
        Reset = rst_n; Stall = st; BranchTaken = br; BranchTarget = bt;
        Jump = jp; JumpTarget = jt;
        if (!rst_n) begin
            m_pc = 32'h0; m_ifi = 32'h0; m_ifpc = 32'h0; m_v = 1'b0; m_boot = 1'b1;
        end else if (jp || br) begin
            m_pc = jp ? jt : bt; m_ifi = 32'h0; m_ifpc = 32'h0; m_v = 1'b0; m_boot = 1'b0;
        end else if (st && !m_boot) begin
            m_pc = m_pc;
        end else begin
            m_ifi = mem(m_pc); m_ifpc = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            m_v = 1'b1; m_boot = 1'b0;
        end
        e.pc = m_pc; e.ifi = m_ifi; e.ifpc = m_ifpc; e.v = m_v;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'h1, 32'h0);
        end else begin
            got = sb.pop_front();
            check("pc",         PCResult,               got.pc);
            check("pcadd",      PCAddResult,            got.pc + 32'd4);
            check("ifid_instr", IFID_Instruction,       got.ifi);
            check("ifid_pcadd", IFID_PCAddResult,       got.ifpc);
            check("ifid_valid", {31'h0, IFID_Valid},    {31'h0, got.v});
        end
    endtask

    initial begin
        Reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
        Jump = 1'b0; JumpTarget = 32'h0;
        m_pc = 32'h0; m_ifi = 32'h0; m_ifpc = 32'h0; m_v = 1'b0; m_boot = 1'b1;

        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("reset_pc", PCResult, 32'h0);

        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("boot_pc", PCResult, 32'h4);
        check("boot_instr", IFID_Instruction, 32'hA5A5_0000);
        check("boot_pcadd", IFID_PCAddResult, 32'h4);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("seq_pc8", PCResult, 32'h8);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stall_pc", PCResult, 32'h8);
        check("stall_pcadd", IFID_PCAddResult, 32'h8);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("release_pc", PCResult, 32'hC);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        check("br_pc", PCResult, 32'h40);
        check("br_bubble", {31'h0, IFID_Valid}, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("br_tgt_pcadd", IFID_PCAddResult, 32'h44);
        check("br_tgt_instr", IFID_Instruction, 32'hA5A5_0040);

        step(1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h100);
        check("jmp_pri_pc", PCResult, 32'h100);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h203, 1'b0, 32'h0);
        check("unaligned_pc", PCResult, 32'h203);

        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        check("wrap_pcadd", PCAddResult, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("wrap_pc", PCResult, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rst_stall_pc", PCResult, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("boot_ignores_stall", PCResult, 32'h4);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("run_stall_pc", PCResult, 32'h4);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("final_pc", PCResult, 32'h14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
Instruction-fetch front end for the 5-stage MIPS pipeline. It holds the program counter register and computes PC+4 internally. It also selects the next PC from sequential, branch and jump sources, and registers the fetched instruction into the IF/ID pipeline register. Handshakes run with the hazard unit (stall) and with the EX stage (branch/jump redirect, which squashes the instruction in the IF/ID register).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_INC, 4, byte increment for sequential fetch.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clk.
Stall  input  1  hazard-unit stall; holds PC and IF/ID.
BranchTaken  input  1  resolved branch is taken; redirect to BranchTarget.
BranchTarget  input  32  branch destination address.
Jump  input  1  jump resolved; redirect to JumpTarget.
JumpTarget  input  32  jump destination address.
Instruction  input  32  instruction-memory read data for the current PCResult (combinational memory).
PCResult  output  32  current PC; drives the instruction-memory address.
PCAddResult  output  32  PCResult + PC_INC, combinational.
IFID_Instruction  output  32  registered instruction.
IFID_PCAddResult  output  32  registered PC+4 of that instruction.
IFID_Valid  output  1  1 = IF/ID holds a live instruction; 0 = bubble.

Behaviour:
- Reset (Reset==0 at the edge): PCResult<=RESET_PC; IFID_Instruction<=0 (NOP); IFID_PCAddResult<=0; IFID_Valid<=0; state<=BOOT. Reset overrides all other inputs, including in the middle of a stall or redirect.
- PCAddResult = PCResult + PC_INC, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- State machine:
  - BOOT: the first cycle after reset. PC advances normally. IF/ID captures the instruction at RESET_PC with Valid=1. Go to RUN. Stall is ignored in BOOT.
  - RUN: normal operation.
  - REDIRECT: entered on the edge where a redirect is taken. IF/ID holds a bubble for exactly that cycle. Return to RUN on the next edge unless another redirect occurs.
- Priority at each edge in RUN/REDIRECT, highest first: Jump, BranchTaken, Stall, sequential.
  - Jump=1: PC<=JumpTarget. IF/ID<=bubble (Instruction=0, PCAddResult=0, Valid=0). state<=REDIRECT.
  - BranchTaken=1 (Jump=0): as Jump, but using BranchTarget.
  - Stall=1 with no redirect: PC and all IF/ID outputs hold their value. State does not change.
  - Otherwise: PC<=PCAddResult. IFID_Instruction<=Instruction. IFID_PCAddResult<=PCAddResult. IFID_Valid<=1. state<=RUN.
- A redirect overrides a simultaneous Stall, because the stalled instruction is on the wrong path.
- Jump and BranchTaken both high: Jump wins.
- Target addresses are used as given, with no alignment check. The low 2 bits are passed through unchanged.
- Latency: an instruction appears in IF/ID one edge after its PC is presented. A redirect target's instruction appears two edges after the redirect is asserted.
- No combinational path from Stall, BranchTaken or Jump to any output except through registers. PCAddResult depends only on PCResult.

Test Plan:
- Reset then sequential run, memory returning PC-tagged data: Reset low 2 cycles, then high → PCResult 0,4,8,12. After edge 1: IFID_Valid=1, IFID_Instruction=data@0, IFID_PCAddResult=4.
- Stall held 3 cycles at PCResult=8 → PCResult stays 8 and IF/ID outputs are unchanged. After release, PCResult=12 on the next edge.
- BranchTaken=1, BranchTarget=0x40 at PCResult=0x10 → next edge: PCResult=0x40, IFID_Valid=0, IFID_Instruction=0. Following edge: IFID_Valid=1, IFID_PCAddResult=0x44.
- Jump=1 to 0x100 and BranchTaken=1 to 0x80, both with Stall=1 → PCResult=0x100 and IF/ID is a bubble (Jump priority, redirect beats stall).
- Wrap-around: redirect to 0xFFFF_FFFC → PCAddResult=0xFFFF_FFFC+4=0. Next sequential PCResult=0.
- Reset asserted during a stall at PCResult=0x20 → next edge: PCResult=RESET_PC, IFID_Valid=0. BOOT behaviour then repeats.
